// File: rtl/auto_attack_sequencer_if.sv
// Attack bus between the automatic attacker and the game core:
// coordinate codes and confirm button out, hit/miss LEDs back.
interface auto_attack_sequencer_if;
    logic [2:0] x_coord;
    logic [2:0] y_coord;
    logic       confirm_n;
    logic       led_green;
    logic       led_red;

    modport master (output x_coord, y_coord, confirm_n, input led_green, led_red);
    modport slave  (input x_coord, y_coord, confirm_n, output led_green, led_red);
endinterface

// File: rtl/auto_attack_sequencer.sv
// Self-play attacker: sweeps the 5x7 board column-major, presses confirm for
// each cell, records the LED hit/miss response and stops when all ships are found.
module auto_attack_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES   = 64,
    parameter int unsigned GAP_CYCLES    = 64
) (
    input  logic                           cpld_clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [5:0]                     ship_cells,
    auto_attack_sequencer_if.master        atk,
    output logic                           busy,
    output logic                           done,
    output logic                           error,
    output logic [5:0]                     hit_count,
    output logic [5:0]                     shot_count,
    output logic                           last_hit
);

    typedef enum logic [2:0] {
        IDLE, SETUP, PRESS, RELEASE, DONE, ERROR
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LAST    = 8'(GAP_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] x_q, x_d, y_q, y_d;
    logic       confirm_n_q, confirm_n_d;
    logic       busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic [5:0] hit_q, hit_d, shot_q, shot_d, ships_q, ships_d;
    logic       last_hit_q, last_hit_d;
    logic       cap_q, cap_d, cap_green_q, cap_green_d, bad_q, bad_d;

    logic one_led, both_led, cap_now, bad_now, green_now;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        y_d         = y_q;
        confirm_n_d = confirm_n_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        hit_d       = hit_q;
        shot_d      = shot_q;
        ships_d     = ships_q;
        last_hit_d  = last_hit_q;
        cap_d       = cap_q;
        cap_green_d = cap_green_q;
        bad_d       = bad_q;

        // Fold the current cycle's LEDs into the capture so the final PRESS
        // cycle counts toward the decision made on that same edge.
        one_led   = atk.led_green ^ atk.led_red;
        both_led  = atk.led_green & atk.led_red;
        cap_now   = cap_q | one_led;
        bad_now   = bad_q | (~cap_q & both_led);
        green_now = cap_q ? cap_green_q : atk.led_green;

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d     = SETUP;
                    ships_d     = ship_cells;
                    hit_d       = '0;
                    shot_d      = '0;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    last_hit_d  = 1'b0;
                    x_d         = '0;
                    y_d         = '0;
                    busy_d      = 1'b1;
                    cnt_d       = '0;
                    confirm_n_d = 1'b1;
                end
            end
            SETUP: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d     = PRESS;
                    cnt_d       = '0;
                    confirm_n_d = 1'b0;
                    cap_d       = 1'b0;
                    cap_green_d = 1'b0;
                    bad_d       = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            PRESS: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d       = '0;
                    confirm_n_d = 1'b1;
                    if (!cap_now || bad_now) begin
                        state_d = ERROR;
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d    = RELEASE;
                        shot_d     = shot_q + 6'd1;
                        hit_d      = hit_q + 6'(green_now);
                        last_hit_d = green_now;
                    end
                end else begin
                    cnt_d       = cnt_q + 8'd1;
                    cap_d       = cap_now;
                    cap_green_d = green_now;
                    bad_d       = bad_now;
                end
            end
            RELEASE: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    // >= so that ship_cells = 0 still ends after the first shot
                    if (hit_q >= ships_q || shot_q == 6'd35) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = SETUP;
                        if (y_q == 3'd6) begin
                            y_d = '0;
                            x_d = x_q + 3'd1;
                        end else begin
                            y_d = y_q + 3'd1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge cpld_clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            confirm_n_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            hit_q       <= '0;
            shot_q      <= '0;
            ships_q     <= '0;
            last_hit_q  <= 1'b0;
            cap_q       <= 1'b0;
            cap_green_q <= 1'b0;
            bad_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            confirm_n_q <= confirm_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            hit_q       <= hit_d;
            shot_q      <= shot_d;
            ships_q     <= ships_d;
            last_hit_q  <= last_hit_d;
            cap_q       <= cap_d;
            cap_green_q <= cap_green_d;
            bad_q       <= bad_d;
        end
    end

    assign atk.x_coord   = x_q;
    assign atk.y_coord   = y_q;
    assign atk.confirm_n = confirm_n_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign hit_count     = hit_q;
    assign shot_count    = shot_q;
    assign last_hit      = last_hit_q;

endmodule

// File: tb/tb_auto_attack_sequencer.sv
// Bench for auto_attack_sequencer: a board responder driven from a hit map and
// a shot-list reference model of the sweep.
module tb_auto_attack_sequencer;

    localparam int S = 2;
    localparam int H = 4;
    localparam int G = 2;
    localparam int P = S + H + G;

    logic       cpld_clk = 1'b0;
    logic       reset;
    logic       start;
    logic [5:0] ship_cells;
    logic       busy, done, error, last_hit;
    logic [5:0] hit_count, shot_count;

    auto_attack_sequencer_if bus ();

    auto_attack_sequencer #(
        .SETTLE_CYCLES(S),
        .HOLD_CYCLES(H),
        .GAP_CYCLES(G)
    ) dut (
        .cpld_clk(cpld_clk),
        .reset(reset),
        .start(start),
        .ship_cells(ship_cells),
        .atk(bus),
        .busy(busy),
        .done(done),
        .error(error),
        .hit_count(hit_count),
        .shot_count(shot_count),
        .last_hit(last_hit)
    );

    always #5 cpld_clk = ~cpld_clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          mode = 0;
    logic [34:0] hitmap = '0;
    int          press_idx = 0;

    // Cycle index within the current confirm_n-low window.
    always @(posedge cpld_clk) press_idx <= bus.confirm_n ? 0 : press_idx + 1;

    // Game-core stand-in: answers during the press according to mode.
    always_comb begin
        int  idx;
        logic cell_hit;
        idx = int'(bus.x_coord) * 7 + int'(bus.y_coord);
        cell_hit = (idx < 35) ? hitmap[idx] : 1'b0;
        bus.led_green = 1'b0;
        bus.led_red   = 1'b0;
        case (mode)
            0: if (!bus.confirm_n) begin bus.led_green = cell_hit; bus.led_red = !cell_hit; end
            2: if (!bus.confirm_n) begin
                   if (press_idx == 1) begin bus.led_green = 1'b1; bus.led_red = 1'b1; end
                   else if (press_idx >= 2) bus.led_red = 1'b1;
               end
            3: if (!bus.confirm_n) begin
                   bus.led_green = 1'b1;
                   bus.led_red   = (press_idx != 0);
               end
            4: if (!bus.confirm_n) begin bus.led_green = cell_hit; bus.led_red = !cell_hit; end
               else begin bus.led_green = 1'b1; bus.led_red = 1'b1; end
            default: ;
        endcase
    end

    task automatic tick(input int n);
        repeat (n) @(posedge cpld_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: the sweep visits cell k = x*7+y in order k = 0,1,2,...; it stops
    // after the shot where hits reach ship_cells, or after 35 shots.
    task automatic run_sweep(input logic [5:0] ships, input logic [34:0] map,
                             input bit hold_start, input bit mid_pulse);
        int n;
        int h;
        int run;
        n = 35;
        h = 0;
        run = 0;
        for (int k = 0; k < 35; k++) begin
            h += int'(map[k]);
            if (h >= int'(ships)) begin
                n = k + 1;
                break;
            end
        end
        hitmap = map;
        ship_cells = ships;
        start = 1'b1;
        tick(1);
        if (!hold_start) start = 1'b0;
        check("busy_at_start", busy, 1);
        check("done_at_start", done, 0);
        check("error_at_start", error, 0);
        check("shots_at_start", shot_count, 0);
        check("x_at_start", bus.x_coord, 0);
        check("y_at_start", bus.y_coord, 0);
        for (int k = 0; k < n; k++) begin
            tick(S);
            check("confirm_low", bus.confirm_n, 0);
            check("x_shot", bus.x_coord, k / 7);
            check("y_shot", bus.y_coord, k % 7);
            if (mid_pulse && k == 1) start = 1'b1;
            tick(H);
            if (mid_pulse && k == 1) start = 1'b0;
            run += int'(map[k]);
            check("confirm_release", bus.confirm_n, 1);
            check("shot_count", shot_count, k + 1);
            check("hit_count", hit_count, run);
            check("last_hit", last_hit, map[k]);
            tick(G);
            if (k == n - 1) begin
                check("done_end", done, 1);
                check("busy_end", busy, 0);
            end else begin
                check("busy_mid", busy, 1);
                check("done_mid", done, 0);
            end
        end
        check("final_hits", hit_count, h);
        check("final_shots", shot_count, n);
        check("final_x", bus.x_coord, (n - 1) / 7);
        check("final_y", bus.y_coord, (n - 1) % 7);
        if (hold_start) begin
            tick(1);
            check("restart_busy", busy, 1);
            check("restart_done", done, 0);
            check("restart_shots", shot_count, 0);
            check("restart_hits", hit_count, 0);
            check("restart_y", bus.y_coord, 0);
            start = 1'b0;
        end
    endtask

    task automatic start_only(input logic [5:0] ships);
        ship_cells = ships;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [34:0] map;
        logic [63:0] rnd;
        reset = 1'b1;
        start = 1'b0;
        ship_cells = '0;
        tick(2);
        check("rst_x", bus.x_coord, 0);
        check("rst_y", bus.y_coord, 0);
        check("rst_confirm", bus.confirm_n, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_hits", hit_count, 0);
        check("rst_shots", shot_count, 0);
        check("rst_last", last_hit, 0);
        reset = 1'b0;
        tick(3);
        check("idle_busy", busy, 0);

        // Hits at (0,1),(1,3),(4,0); a stray start pulse during shot 1.
        mode = 0;
        map = '0;
        map[1] = 1'b1;
        map[10] = 1'b1;
        map[28] = 1'b1;
        run_sweep(6'd3, map, 1'b0, 1'b1);

        // All misses with more ships than cells: full 35-shot sweep.
        run_sweep(6'd40, '0, 1'b0, 1'b0);

        // ship_cells = 0 with a hit at (0,0).
        map = '0;
        map[0] = 1'b1;
        run_sweep(6'd0, map, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            mode = ($urandom % 2 == 0) ? 0 : 4;
            rnd = {$urandom, $urandom};
            map = rnd[34:0];
            run_sweep(6'($urandom_range(0, 40)), map, 1'b0, 1'b0);
        end
        mode = 0;

        // Silent responder.
        mode = 1;
        start_only(6'd5);
        tick(S + H - 1);
        check("silent_no_err_yet", error, 0);
        tick(1);
        check("silent_error", error, 1);
        check("silent_busy", busy, 0);
        check("silent_confirm", bus.confirm_n, 1);
        check("silent_shots", shot_count, 0);

        // Both LEDs in the second PRESS cycle, starting from ERROR.
        mode = 2;
        start_only(6'd5);
        check("both_err_cleared", error, 0);
        tick(S + H);
        check("both_error", error, 1);
        check("both_busy", busy, 0);
        check("both_shots", shot_count, 0);

        // Green first, then both: a normal hit.
        mode = 3;
        start_only(6'd5);
        tick(S + H);
        check("gfirst_error", error, 0);
        check("gfirst_shots", shot_count, 1);
        check("gfirst_hits", hit_count, 1);
        check("gfirst_last", last_hit, 1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;

        // Reset mid-PRESS of shot 5.
        mode = 0;
        hitmap = '0;
        hitmap[2] = 1'b1;
        start_only(6'd40);
        tick(5 * P + S + 1);
        check("pre_reset_press", bus.confirm_n, 0);
        check("pre_reset_y", bus.y_coord, 5);
        reset = 1'b1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("mid_rst_confirm", bus.confirm_n, 1);
        check("mid_rst_x", bus.x_coord, 0);
        check("mid_rst_y", bus.y_coord, 0);
        check("mid_rst_hits", hit_count, 0);
        check("mid_rst_shots", shot_count, 0);
        check("mid_rst_busy", busy, 0);
        reset = 1'b0;
        tick(3);
        check("post_rst_idle", busy, 0);
        check("post_rst_confirm", bus.confirm_n, 1);
        map = '0;
        map[4] = 1'b1;
        run_sweep(6'd1, map, 1'b0, 1'b0);

        // start held high: immediate restart after DONE.
        map = '0;
        map[3] = 1'b1;
        map[5] = 1'b1;
        run_sweep(6'd2, map, 1'b1, 1'b0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
